// File: rtl/display_scan_decoder_pkg.sv
// Shared constants for the multiplexed seven-segment display path: digit count,
// segment bit positions and the hex-to-segment encoding table.
package display_scan_decoder_pkg;

    localparam int unsigned NumDigits = 8;
    localparam int unsigned SegDpBit  = 7;
    localparam int unsigned SegGBit   = 6;
    localparam int unsigned SegABit   = 0;

    typedef struct packed {
        logic [3:0] nibble;
        logic       dp;
        logic       err;
    } digit_slot_t;

    // Active-high {g,f,e,d,c,b,a} pattern for each hex digit.
    function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
        logic [6:0] pat;
        case (nibble)
            4'h0: pat = 7'h3F;
            4'h1: pat = 7'h06;
            4'h2: pat = 7'h5B;
            4'h3: pat = 7'h4F;
            4'h4: pat = 7'h66;
            4'h5: pat = 7'h6D;
            4'h6: pat = 7'h7D;
            4'h7: pat = 7'h07;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h6F;
            4'hA: pat = 7'h77;
            4'hB: pat = 7'h7C;
            4'hC: pat = 7'h39;
            4'hD: pat = 7'h5E;
            4'hE: pat = 7'h79;
            default: pat = 7'h71;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/display_scan_decoder_aux_seg_decode.sv
// Combinational inverse of the segment table: active-high pattern in, nibble out,
// with an invalid flag for patterns that match no hex digit.
module aux_seg_decode
    import display_scan_decoder_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] nibble_o,
    output logic       invalid_o
);

    always_comb begin
        nibble_o  = 4'h0;
        invalid_o = 1'b1;
        for (int unsigned n = 0; n < 16; n++) begin
            if (seg_i == seg_encode(4'(n))) begin
                nibble_o  = 4'(n);
                invalid_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/display_scan_decoder.sv
// Watches an active-low eight-digit seven-segment scan and recovers the displayed
// 32-bit hex word, one frame per complete set of stable digit captures.
module display_scan_decoder
    import display_scan_decoder_pkg::*;
#(
    parameter int unsigned SyncStages   = 2,
    parameter int unsigned StableCycles = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  seg_n,
    input  logic [7:0]  an_n,
    output logic [31:0] data,
    output logic [7:0]  dp,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        data_changed
);

    localparam int unsigned     CntW   = $clog2(StableCycles + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(StableCycles);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSettle = 2'd1;
    localparam logic [1:0] StHeld   = 2'd2;

    logic [7:0] s_seg, s_an;

    if (SyncStages == 0) begin : g_no_sync
        assign s_seg = seg_n;
        assign s_an  = an_n;
    end else begin : g_sync
        logic [15:0] sync_q [SyncStages];

        // Reset to all-ones so the synchronizer looks like a blanked display.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int unsigned i = 0; i < SyncStages; i++) sync_q[i] <= '1;
            end else begin
                sync_q[0] <= {seg_n, an_n};
                for (int unsigned i = 1; i < SyncStages; i++) sync_q[i] <= sync_q[i-1];
            end
        end

        assign {s_seg, s_an} = sync_q[SyncStages-1];
    end

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [15:0]     s_prev_q, s_prev_d;
    logic [7:0]      got_q, got_d;
    digit_slot_t [NumDigits-1:0] shadow_q, shadow_d;
    logic [31:0]     data_q, data_d;
    logic [7:0]      dp_q, dp_d;
    logic            frame_valid_q, frame_valid_d;
    logic            frame_err_q, frame_err_d;
    logic            data_changed_q, data_changed_d;

    logic       legal, same, capture, emit;
    logic [2:0] dig_idx;
    logic [3:0] dec_nibble;
    logic       dec_invalid;

    aux_seg_decode u_seg_decode (
        .seg_i     (~s_seg[SegGBit:SegABit]),
        .nibble_o  (dec_nibble),
        .invalid_o (dec_invalid)
    );

    assign legal = ($countones(~s_an) == 1);
    assign same  = ({s_seg, s_an} == s_prev_q);

    always_comb begin
        dig_idx = 3'd0;
        for (int unsigned i = 0; i < NumDigits; i++) begin
            if (!s_an[i]) dig_idx = 3'(i);
        end
    end

    // Stability FSM: a select must be seen StableCycles times in a row to capture.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        capture  = 1'b0;
        s_prev_d = {s_seg, s_an};
        if (!legal) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else if (!(state_q == StHeld && same)) begin
            if (state_q != StSettle || !same) begin
                cnt_d = CntOne;
            end else begin
                cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;
            end
            if (cnt_d == CntMax) begin
                capture = 1'b1;
                state_d = StHeld;
            end else begin
                state_d = StSettle;
            end
        end
    end

    // Frame assembly; a capture in the emit cycle lands in the new frame.
    always_comb begin
        emit           = (got_q == 8'hFF);
        got_d          = emit ? 8'h00 : got_q;
        shadow_d       = shadow_q;
        data_d         = data_q;
        dp_d           = dp_q;
        frame_err_d    = frame_err_q;
        frame_valid_d  = emit;
        data_changed_d = 1'b0;
        if (emit) begin
            frame_err_d = 1'b0;
            for (int unsigned i = 0; i < NumDigits; i++) begin
                data_d[4*i +: 4] = shadow_q[i].nibble;
                dp_d[i]          = shadow_q[i].dp;
                frame_err_d      = frame_err_d | shadow_q[i].err;
                shadow_d[i].err  = 1'b0;
            end
            data_changed_d = (data_d != data_q);
        end
        if (capture) begin
            got_d[dig_idx]    = 1'b1;
            shadow_d[dig_idx] = '{nibble: dec_nibble, dp: ~s_seg[SegDpBit], err: dec_invalid};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            s_prev_q       <= '1;
            got_q          <= '0;
            shadow_q       <= '0;
            data_q         <= '0;
            dp_q           <= '0;
            frame_valid_q  <= 1'b0;
            frame_err_q    <= 1'b0;
            data_changed_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            s_prev_q       <= s_prev_d;
            got_q          <= got_d;
            shadow_q       <= shadow_d;
            data_q         <= data_d;
            dp_q           <= dp_d;
            frame_valid_q  <= frame_valid_d;
            frame_err_q    <= frame_err_d;
            data_changed_q <= data_changed_d;
        end
    end

    assign data         = data_q;
    assign dp           = dp_q;
    assign frame_valid  = frame_valid_q;
    assign frame_err    = frame_err_q;
    assign data_changed = data_changed_q;

endmodule

// File: tb/tb_display_scan_decoder.sv
// Self-checking bench: drives pad-level scans and compares emitted frames against a
// segment-run reference model built from the display's capture and frame rules.
module tb_display_scan_decoder;

    localparam int unsigned SC = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  seg_n, an_n;
    logic [31:0] data;
    logic [7:0]  dp;
    logic        frame_valid, frame_err, data_changed;

    always #5 clk = ~clk;

    display_scan_decoder #(
        .SyncStages   (2),
        .StableCycles (SC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .seg_n        (seg_n),
        .an_n         (an_n),
        .data         (data),
        .dp           (dp),
        .frame_valid  (frame_valid),
        .frame_err    (frame_err),
        .data_changed (data_changed)
    );

    typedef struct {
        logic [31:0] data;
        logic [7:0]  dp;
        logic        err;
        logic        changed;
    } frame_t;

    int checks = 0;
    int errors = 0;
    int frames_seen = 0;
    int frames_pushed = 0;
    frame_t exp_q[$];

    // Reference model state: current pad run and the frame being collected.
    logic [31:0] m_data, m_prev;
    logic [7:0]  m_dp, m_err, m_got;
    logic [7:0]  m_an, m_seg;
    bit          m_run_valid, m_captured;
    int          m_run;

    function automatic logic [6:0] enc(input logic [3:0] v);
        logic [6:0] t [16];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return t[v];
    endfunction

    // {invalid, nibble}
    function automatic logic [4:0] dec(input logic [6:0] p);
        for (int n = 0; n < 16; n++) begin
            if (enc(4'(n)) == p) return {1'b0, 4'(n)};
        end
        return 5'h10;
    endfunction

    function automatic logic [7:0] pad_seg(input logic [3:0] v, input logic dp_on);
        return {~dp_on, ~enc(v)};
    endfunction

    task automatic model_reset();
        m_data = '0; m_prev = '0; m_dp = '0; m_err = '0; m_got = '0;
        m_run_valid = 0; m_captured = 0; m_run = 0;
        exp_q.delete();
    endtask

    task automatic model_capture(input logic [7:0] an, input logic [7:0] seg);
        int i;
        logic [4:0] d;
        frame_t f;
        i = 0;
        for (int k = 0; k < 8; k++) if (!an[k]) i = k;
        d = dec(~seg[6:0]);
        m_data[4*i +: 4] = d[3:0];
        m_dp[i]  = ~seg[7];
        m_err[i] = d[4];
        m_got[i] = 1'b1;
        if (m_got == 8'hFF) begin
            f.data = m_data; f.dp = m_dp; f.err = |m_err; f.changed = (m_data != m_prev);
            exp_q.push_back(f);
            frames_pushed++;
            m_prev = m_data;
            m_got = '0;
            m_err = '0;
        end
    endtask

    // Hold a pad value for n sampling edges and account for it in the model.
    task automatic hold(input logic [7:0] an, input logic [7:0] seg, input int n);
        an_n  = an;
        seg_n = seg;
        if ($countones(~an) != 1) begin
            m_run_valid = 0;
        end else begin
            if (!m_run_valid || an != m_an || seg != m_seg) begin
                m_run = 0;
                m_captured = 0;
            end
            m_run_valid = 1; m_an = an; m_seg = seg;
            m_run += n;
            if (!m_captured && m_run >= int'(SC)) begin
                m_captured = 1;
                model_capture(an, seg);
            end
        end
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan_word(input logic [31:0] w, input logic [7:0] dps, input int dwell,
                             input int bad_digit);
        logic [7:0] s;
        for (int i = 0; i < 8; i++) begin
            s = pad_seg(w[4*i +: 4], dps[i]);
            if (i == bad_digit) s[6:0] = 7'h7F;
            hold(~(8'd1 << i), s, dwell);
        end
    endtask

    task automatic drain();
        hold(8'hFF, 8'hFF, 30);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && frame_valid === 1'b1) begin
            frame_t e;
            frames_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_frame: got data=%h dp=%h err=%b, none required",
                         data, dp, frame_err);
            end else begin
                e = exp_q.pop_front();
                if ({data, dp, frame_err, data_changed} !== {e.data, e.dp, e.err, e.changed}) begin
                    errors++;
                    $display("FAIL frame: got data=%h dp=%h err=%b chg=%b, need %h %h %b %b",
                             data, dp, frame_err, data_changed, e.data, e.dp, e.err, e.changed);
                end
            end
        end else if (rst_n === 1'b1 && data_changed !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL changed_without_valid: data_changed=%b, need 0", data_changed);
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; an_n = 8'hFF; seg_n = 8'hFF;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({data, dp, frame_valid, frame_err, data_changed} !== 43'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h/%h/%b%b%b, need all 0",
                     data, dp, frame_valid, frame_err, data_changed);
        end
        rst_n = 1'b1;
        hold(8'hFF, 8'hFF, 5);
        checks++;
        if ({data, frame_valid} !== 33'd0) begin
            errors++;
            $display("FAIL post_reset_idle: got data=%h valid=%b, need 0", data, frame_valid);
        end
    endtask

    task automatic test_clean_scan();
        int f0 = frames_seen;
        scan_word(32'h1234ABCD, 8'h00, 20, -1);
        scan_word(32'h1234ABCD, 8'h00, 20, -1);
        drain();
        checks++;
        if (frames_seen - f0 !== 2) begin
            errors++;
            $display("FAIL clean_frame_count: got %0d, need 2", frames_seen - f0);
        end
        checks++;
        if ({data, frame_err} !== {32'h1234ABCD, 1'b0}) begin
            errors++;
            $display("FAIL clean_data: got %h err=%b, need 1234abcd err=0", data, frame_err);
        end
    endtask

    task automatic test_bad_digit();
        int f0 = frames_seen;
        scan_word(32'h1234ABCD, 8'h00, 20, 3);
        drain();
        checks++;
        if ({data, frame_err} !== {32'h12340BCD, 1'b1}) begin
            errors++;
            $display("FAIL bad_digit: got %h err=%b, need 12340bcd err=1", data, frame_err);
        end
        scan_word(32'h1234ABCD, 8'h00, 20, -1);
        drain();
        checks++;
        if ({data, frame_err, frames_seen - f0} !== {32'h1234ABCD, 1'b0, 32'd2}) begin
            errors++;
            $display("FAIL bad_then_clean: got %h err=%b frames=%0d, need 1234abcd 0 2",
                     data, frame_err, frames_seen - f0);
        end
    endtask

    task automatic test_short_dwell();
        int f0 = frames_seen;
        for (int r = 0; r < 3; r++) scan_word(32'h89ABCDEF, 8'h00, 10, -1);
        drain();
        checks++;
        if (frames_seen - f0 !== 0) begin
            errors++;
            $display("FAIL short_dwell: got %0d frames, need 0", frames_seen - f0);
        end
    endtask

    task automatic test_dp();
        int f0 = frames_seen;
        scan_word(32'h00000000, 8'h81, 20, -1);
        drain();
        checks++;
        if ({data, dp, frame_err, frames_seen - f0} !== {32'h0, 8'h81, 1'b0, 32'd1}) begin
            errors++;
            $display("FAIL dp: got data=%h dp=%h err=%b frames=%0d, need 0 81 0 1",
                     data, dp, frame_err, frames_seen - f0);
        end
    endtask

    task automatic test_glitches();
        int f0 = frames_seen;
        logic [31:0] w = 32'hDEADBEEF;
        for (int i = 0; i < 8; i++) begin
            hold(~(8'd1 << i), pad_seg(w[4*i +: 4], 1'b0), 20);
            hold(8'hFF, 8'hFF, 2);
            hold(~((8'd1 << i) | (8'd1 << ((i + 1) % 8))), pad_seg(4'h8, 1'b0), 2);
        end
        drain();
        checks++;
        if ({data, frames_seen - f0} !== {32'hDEADBEEF, 32'd1}) begin
            errors++;
            $display("FAIL glitch_scan: got %h frames=%0d, need deadbeef 1",
                     data, frames_seen - f0);
        end
    endtask

    task automatic test_stall();
        int f0 = frames_seen;
        hold(~8'h04, pad_seg(4'h5, 1'b0), 400);
        drain();
        checks++;
        if (frames_seen - f0 !== 0) begin
            errors++;
            $display("FAIL stall: got %0d frames, need 0", frames_seen - f0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int f0;
        for (int i = 0; i < 5; i++) hold(~(8'd1 << i), pad_seg(4'h3, 1'b1), 20);
        an_n = 8'hFF; seg_n = 8'hFF;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({data, dp, frame_valid, frame_err, data_changed} !== 43'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %h/%h/%b%b%b, need all 0",
                     data, dp, frame_valid, frame_err, data_changed);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        f0 = frames_seen;
        m_run_valid = 0;
        hold(8'hFF, 8'hFF, 3);
        scan_word(32'h0F0F0F0F, 8'h00, 20, -1);
        drain();
        checks++;
        if ({data, dp, frames_seen - f0} !== {32'h0F0F0F0F, 8'h00, 32'd1}) begin
            errors++;
            $display("FAIL mid_reset_frame: got %h dp=%h frames=%0d, need 0f0f0f0f 00 1",
                     data, dp, frames_seen - f0);
        end
    endtask

    task automatic test_random();
        int f0 = frames_seen;
        int p0 = frames_pushed;
        logic [31:0] w;
        logic [7:0]  dps, s;
        int bad;
        for (int r = 0; r < 8; r++) begin
            w   = $urandom;
            dps = 8'($urandom);
            bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
            for (int i = 0; i < 8; i++) begin
                s = pad_seg(w[4*i +: 4], dps[i]);
                if (i == bad) s[6:0] = 7'($urandom);
                hold(~(8'd1 << i), s, int'($urandom_range(SC, SC + 12)));
                case ($urandom_range(0, 3))
                    0: hold(8'hFF, 8'hFF, int'($urandom_range(1, 3)));
                    1: hold(~(8'd1 << $urandom_range(0, 7)), 8'($urandom),
                            int'($urandom_range(1, SC - 6)));
                    default: ;
                endcase
            end
        end
        drain();
        checks++;
        if (frames_seen - f0 !== frames_pushed - p0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_frames: got %0d frames, need %0d (pending %0d)",
                     frames_seen - f0, frames_pushed - p0, exp_q.size());
        end
        checks++;
        if (data !== m_prev) begin
            errors++;
            $display("FAIL random_last_data: got %h, need %h", data, m_prev);
        end
    endtask

    initial begin
        test_reset();
        test_clean_scan();
        test_bad_digit();
        test_short_dwell();
        test_dp();
        test_glitches();
        test_stall();
        test_reset_mid_frame();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_frames: got %0d still pending, need 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
